// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue: records fetched predictions, resolves the oldest
// against execute, trains the predictor, and redirects/flushes fetch on a mispredict.
module branch_resolve_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [31:0]         push_pc,
  input  logic                push_pred_taken,
  input  logic [31:0]         push_pred_target,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic [31:0]         res_target,
  output logic                upd_en,
  output logic [31:0]         upd_pc,
  output logic                upd_val,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic [PTR_BITS:0]   occupancy,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts,
  output logic                err_underflow
);
  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);

  logic [31:0]         pc_q  [DEPTH];
  logic [31:0]         tgt_q [DEPTH];
  logic [DEPTH-1:0]    pt_q;

  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_BITS:0]   cnt_q, cnt_d;
  logic                upd_en_q, upd_val_q, redir_q, err_q;
  logic [31:0]         upd_pc_q, redir_pc_q, br_q, mp_q;

  logic        push_acc, res_acc, mispred, flush;
  logic [31:0] h_pc, h_tgt;
  logic        h_pt;

  assign push_ready = (cnt_q != FULL_CNT);
  assign occupancy  = cnt_q;
  assign push_acc   = push_valid && push_ready;
  assign res_acc    = res_valid && (cnt_q != '0);

  assign h_pc    = pc_q[head_q];
  assign h_tgt   = tgt_q[head_q];
  assign h_pt    = pt_q[head_q];
  assign mispred = (h_pt != res_taken) || (res_taken && (h_tgt != res_target));
  assign flush   = res_acc && mispred;

  // A flush drops every entry, including a same-cycle push (wrong path).
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = tail_q;
      cnt_d  = '0;
    end else begin
      if (push_acc) tail_d = tail_q + PTR_BITS'(1);
      if (res_acc)  head_d = head_q + PTR_BITS'(1);
      cnt_d = cnt_q + (PTR_BITS+1)'(push_acc) - (PTR_BITS+1)'(res_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !flush) begin
      pc_q[tail_q]  <= push_pc;
      pt_q[tail_q]  <= push_pred_taken;
      tgt_q[tail_q] <= push_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      upd_en_q   <= 1'b0;
      upd_pc_q   <= '0;
      upd_val_q  <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      br_q       <= '0;
      mp_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      upd_en_q <= res_acc;
      redir_q  <= flush;
      if (res_valid && !res_acc) err_q <= 1'b1;
      if (res_acc) begin
        upd_pc_q  <= h_pc;
        upd_val_q <= res_taken;
        if (br_q != '1) br_q <= br_q + 32'd1;
      end
      if (flush) begin
        redir_pc_q <= res_taken ? res_target : h_pc + 32'd4;
        if (mp_q != '1) mp_q <= mp_q + 32'd1;
      end
    end
  end

  assign upd_en           = upd_en_q;
  assign upd_pc           = upd_pc_q;
  assign upd_val          = upd_val_q;
  assign redirect_valid   = redir_q;
  assign redirect_pc      = redir_pc_q;
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
  assign err_underflow    = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int PB    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, push_valid, push_pred_taken, res_valid, res_taken;
  logic [31:0] push_pc, push_pred_target, res_target;
  logic        push_ready, upd_en, upd_val, redirect_valid, err_underflow;
  logic [31:0] upd_pc, redirect_pc, stat_branches, stat_mispredicts;
  logic [PB:0] occupancy;

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_val(upd_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts), .err_underflow(err_underflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic        e_upd_en, e_upd_val, e_redir, e_err;
  logic [31:0] e_upd_pc, e_redir_pc, e_br, e_mp;
  int checks = 0;
  int errors = 0;

  task automatic idle();
    reset = 0; push_valid = 0; res_valid = 0; res_taken = 0;
    push_pc = 0; push_pred_taken = 0; push_pred_target = 0; res_target = 0;
  endtask

  // Advance one clock: apply the model's rules to the inputs seen at this edge.
  task automatic cyc();
    if (reset) begin
      mq.delete();
      e_upd_en = 0; e_upd_val = 0; e_redir = 0; e_err = 0;
      e_upd_pc = 0; e_redir_pc = 0; e_br = 0; e_mp = 0;
    end else begin
      bit pok;
      pok = push_valid && (mq.size() < DEPTH);
      e_upd_en = 0;
      e_redir  = 0;
      if (res_valid && mq.size() == 0) e_err = 1;
      else if (res_valid) begin
        ent_t h;
        bit   mis;
        h   = mq[0];
        mis = (h.pt != res_taken) || (res_taken && h.tgt != res_target);
        e_upd_en = 1; e_upd_pc = h.pc; e_upd_val = res_taken;
        if (e_br != 32'hFFFF_FFFF) e_br = e_br + 1;
        if (mis) begin
          e_redir = 1;
          e_redir_pc = res_taken ? res_target : h.pc + 32'd4;
          if (e_mp != 32'hFFFF_FFFF) e_mp = e_mp + 1;
          mq.delete();
          pok = 0;
        end else void'(mq.pop_front());
      end
      if (pok) mq.push_back('{push_pc, push_pred_taken, push_pred_target});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    push_valid = 1; push_pc = pc; push_pred_taken = pt; push_pred_target = tgt;
    cyc();
    push_valid = 0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    res_valid = 1; res_taken = tk; res_target = tgt;
    cyc();
    res_valid = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; cyc(); reset = 0;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if ({upd_en, upd_val, redirect_valid, err_underflow} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {upd_en, upd_val, redirect_valid, err_underflow}); end
    checks++; if ({upd_pc, redirect_pc, stat_branches, stat_mispredicts} !== 128'h0) begin errors++; $display("FAIL reset_words got %h %h %h %h want 0", upd_pc, redirect_pc, stat_branches, stat_mispredicts); end
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
    for (int i = 0; i < 3; i++) push(pcs[i], 0, 0);
    checks++; if (occupancy !== 3) begin errors++; $display("FAIL basic_occ3 got %0d want 3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      resolve(0, 0);
      checks++; if ({upd_en, upd_val, redirect_valid} !== 3'b100 || upd_pc !== pcs[i]) begin
        errors++; $display("FAIL basic_upd%0d got en=%b val=%b redir=%b pc=%h want 1 0 0 %h", i, upd_en, upd_val, redirect_valid, upd_pc, pcs[i]);
      end
    end
    cyc();
    checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL basic_pulse_end got %b want 0", upd_en); end
    checks++; if (occupancy !== 0 || stat_branches !== 3) begin errors++; $display("FAIL basic_final got occ=%0d br=%0d want 0 3", occupancy, stat_branches); end
  endtask

  task automatic test_full();
    logic [31:0] want [4];
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i) * 4, 0, 0);
    checks++; if (push_ready !== 1'b0 || occupancy !== 4) begin errors++; $display("FAIL full_ready got rdy=%b occ=%0d want 0 4", push_ready, occupancy); end
    push(32'hAAA, 0, 0);
    checks++; if (occupancy !== 4) begin errors++; $display("FAIL full_5th got occ=%0d want 4", occupancy); end
    push_valid = 1; push_pc = 32'hBBB; push_pred_taken = 0;
    res_valid = 1; res_taken = 0;
    cyc();
    res_valid = 0;
    checks++; if (occupancy !== 3) begin errors++; $display("FAIL full_no_bypass got occ=%0d want 3", occupancy); end
    cyc();
    push_valid = 0;
    checks++; if (occupancy !== 4) begin errors++; $display("FAIL full_next_push got occ=%0d want 4", occupancy); end
    want[0] = 32'h1004; want[1] = 32'h1008; want[2] = 32'h100C; want[3] = 32'hBBB;
    for (int i = 0; i < 4; i++) begin
      resolve(0, 0);
      checks++; if (upd_en !== 1'b1 || upd_pc !== want[i]) begin errors++; $display("FAIL full_drain%0d got en=%b pc=%h want 1 %h", i, upd_en, upd_pc, want[i]); end
    end
  endtask

  task automatic test_mispredict();
    push(32'h400, 1, 32'h800);
    push(32'h404, 0, 0);
    push(32'h408, 0, 0);
    resolve(0, 0);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h404) begin errors++; $display("FAIL mis_redirect got v=%b pc=%h want 1 00000404", redirect_valid, redirect_pc); end
    checks++; if (upd_en !== 1'b1 || upd_val !== 1'b0 || upd_pc !== 32'h400) begin errors++; $display("FAIL mis_train got en=%b val=%b pc=%h want 1 0 00000400", upd_en, upd_val, upd_pc); end
    checks++; if (occupancy !== 0 || push_ready !== 1'b1 || stat_mispredicts !== 1) begin errors++; $display("FAIL mis_flush got occ=%0d rdy=%b mp=%0d want 0 1 1", occupancy, push_ready, stat_mispredicts); end
    cyc();
    checks++; if (redirect_valid !== 1'b0 || upd_en !== 1'b0) begin errors++; $display("FAIL mis_pulse got redir=%b upd=%b want 0 0", redirect_valid, upd_en); end
  endtask

  task automatic test_flush_push();
    push(32'h500, 1, 32'h600);
    push_valid = 1; push_pc = 32'h504; push_pred_taken = 0;
    res_valid = 1; res_taken = 1; res_target = 32'h700;
    cyc();
    push_valid = 0; res_valid = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h700) begin errors++; $display("FAIL flushpush_redirect got v=%b pc=%h want 1 00000700", redirect_valid, redirect_pc); end
    checks++; if (occupancy !== 0 || stat_mispredicts !== 2) begin errors++; $display("FAIL flushpush_discard got occ=%0d mp=%0d want 0 2", occupancy, stat_mispredicts); end
  endtask

  task automatic test_underflow_reset();
    res_valid = 1; res_taken = 0;
    cyc();
    res_valid = 0;
    checks++; if (err_underflow !== 1'b1 || upd_en !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL under_flag got err=%b upd=%b redir=%b want 1 0 0", err_underflow, upd_en, redirect_valid); end
    checks++; if (stat_branches !== e_br || stat_mispredicts !== e_mp) begin errors++; $display("FAIL under_stats got %0d %0d want %0d %0d", stat_branches, stat_mispredicts, e_br, e_mp); end
    push(32'h900, 0, 0);
    push(32'h904, 0, 0);
    checks++; if (err_underflow !== 1'b1 || occupancy !== 2) begin errors++; $display("FAIL under_sticky got err=%b occ=%0d want 1 2", err_underflow, occupancy); end
    reset = 1; res_valid = 1; res_taken = 1; res_target = 32'h1234;
    cyc();
    reset = 0; res_valid = 0;
    checks++; if ({push_ready, upd_en, upd_val, redirect_valid, err_underflow} !== 5'b10000 || occupancy !== 0) begin errors++; $display("FAIL rst_mid_flags got rdy/upd/val/redir/err=%b occ=%0d want 10000 0", {push_ready, upd_en, upd_val, redirect_valid, err_underflow}, occupancy); end
    checks++; if ({upd_pc, redirect_pc, stat_branches, stat_mispredicts} !== 128'h0) begin errors++; $display("FAIL rst_mid_words got %h %h %h %h want 0", upd_pc, redirect_pc, stat_branches, stat_mispredicts); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(0, 59) == 0);
      push_valid       = $urandom_range(0, 1);
      push_pc          = {$urandom_range(0, 255), 2'b00};
      push_pred_taken  = $urandom_range(0, 1);
      push_pred_target = {$urandom_range(0, 3), 4'h0};
      res_valid        = ($urandom_range(0, 2) != 0);
      if (mq.size() != 0 && $urandom_range(0, 9) < 7) begin
        res_taken  = mq[0].pt;
        res_target = mq[0].tgt;
      end else begin
        res_taken  = $urandom_range(0, 1);
        res_target = {$urandom_range(0, 3), 4'h0};
      end
      cyc();
      checks++; if (upd_en !== e_upd_en || redirect_valid !== e_redir) begin errors++; $display("FAIL rnd%0d_pulses got upd=%b redir=%b want %b %b", n, upd_en, redirect_valid, e_upd_en, e_redir); end
      checks++; if (occupancy !== mq.size() || push_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd%0d_occ got occ=%0d rdy=%b want %0d", n, occupancy, push_ready, mq.size()); end
      checks++; if (stat_branches !== e_br || stat_mispredicts !== e_mp || err_underflow !== e_err) begin errors++; $display("FAIL rnd%0d_stats got br=%0d mp=%0d err=%b want %0d %0d %b", n, stat_branches, stat_mispredicts, err_underflow, e_br, e_mp, e_err); end
      if (e_upd_en) begin
        checks++; if (upd_pc !== e_upd_pc || upd_val !== e_upd_val) begin errors++; $display("FAIL rnd%0d_upd got pc=%h val=%b want %h %b", n, upd_pc, upd_val, e_upd_pc, e_upd_val); end
      end
      if (e_redir) begin
        checks++; if (redirect_pc !== e_redir_pc) begin errors++; $display("FAIL rnd%0d_redir_pc got %h want %h", n, redirect_pc, e_redir_pc); end
      end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_flush_push();
    test_underflow_reset();
    idle(); reset = 1; cyc(); reset = 0;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracking queue between fetch (where `BranchPredictor` produces `prediction`) and execute (where branches resolve). Each fetched branch is recorded with its predicted direction and target. When execute resolves the oldest branch, the block:
- compares the actual outcome with the prediction,
- drives the predictor's `update_en`/`update_val` training pair,
- issues a fetch redirect and queue flush on a mispredict,
- keeps saturating branch and mispredict statistics.

## Interface

Parameters:
- DEPTH, 4: number of in-flight branch entries; power of two, ≥2.
- PTR_BITS, 2: log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- push_valid  input  1  fetch presents a branch this cycle.
- push_ready  output  1  queue can accept; equals !full.
- push_pc  input  32  PC of the fetched branch.
- push_pred_taken  input  1  predictor direction for that branch.
- push_pred_target  input  32  predicted target; ignored when push_pred_taken=0.
- res_valid  input  1  execute resolves the oldest branch this cycle.
- res_taken  input  1  actual direction.
- res_target  input  32  actual taken target.
- upd_en  output  1  one-cycle training pulse to the predictor.
- upd_pc  output  32  PC being trained.
- upd_val  output  1  actual outcome being trained.
- redirect_valid  output  1  one-cycle mispredict redirect pulse.
- redirect_pc  output  32  correct fetch PC.
- occupancy  output  PTR_BITS+1  valid entries.
- stat_branches  output  32  resolved branches, saturating.
- stat_mispredicts  output  32  mispredicts, saturating.
- err_underflow  output  1  sticky; set when res_valid arrives while the queue is empty.

## Operation

- Storage is a circular buffer with head pointer, tail pointer and count.
  - Each entry holds {pc, pred_taken, pred_target}.
  - Pointers wrap modulo DEPTH.
- Push is accepted when push_valid && push_ready. The entry is written at tail, tail increments, count increments.
- Resolve is accepted when res_valid && count != 0. The head entry is compared against the actual outcome.
  - Mispredict = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
  - Correct prediction: head increments, count decrements.
  - Mispredict: flush. head = tail, count = 0, and any push accepted in the same cycle is discarded as wrong-path.
- Same-cycle push and correct resolve: both take effect and count is unchanged.
  - Push is never allowed while full, even when a resolve is accepted in the same cycle. No bypass.
- Every accepted resolve produces the training outputs on the next cycle: upd_en=1, upd_pc=head pc, upd_val=res_taken.
- Every mispredict also produces the redirect on the next cycle: redirect_valid=1.
  - redirect_pc = res_taken ? res_target : head pc + 32'd4, with 32-bit wrap.
- Statistics, per accepted resolve:
  - stat_branches increments; stat_mispredicts increments on a mispredict.
  - Both hold at 32'hFFFF_FFFF once saturated.
- res_valid with count == 0: resolve is ignored, err_underflow is set, and no upd_en or redirect is produced.

## Timing

- Reset values: push_ready=1, upd_en=0, upd_pc=0, upd_val=0, redirect_valid=0, redirect_pc=0, occupancy=0, both stats 0, err_underflow=0.
  - Head, tail and count are 0. Entry contents are don't-care.
- push_ready and occupancy are combinational from registered count.
- Resolve-to-training latency is 1 cycle; resolve-to-redirect latency is 1 cycle. Both are registered outputs.
- upd_en and redirect_valid are single-cycle pulses. Back-to-back resolves give back-to-back pulses.
- The flush is visible the cycle after the mispredict resolve: occupancy=0 and push_ready=1.
- Reset asserted mid-operation: takes priority over push and resolve. All pending entries are dropped. Pulses due next cycle are suppressed, so the outputs read their reset values.

## Test plan

- Push 3 branches (pc 0x100/0x200/0x300, all predicted not-taken), then resolve each not-taken.
  - Required: 3 upd_en pulses with upd_pc 0x100/0x200/0x300 and upd_val=0.
  - Required: no redirect, occupancy back to 0, stat_branches=3.
- Fill to DEPTH=4.
  - Required: push_ready=0, and a 5th push_valid is not accepted.
  - Then resolve one correctly while push_valid is high. Required: push not accepted that cycle, accepted the next cycle, occupancy=4.
- Push pc 0x400 predicted taken to 0x800, plus 2 younger entries; resolve 0x400 not-taken.
  - Required: next cycle redirect_valid=1, redirect_pc=0x404, upd_val=0.
  - Required: occupancy=0 and stat_mispredicts=1.
- Push pc 0x500 predicted taken to 0x600; resolve taken to 0x700 while also pushing pc 0x504.
  - Required: redirect_pc=0x700, the push of 0x504 is discarded, occupancy=0.
- Resolve on an empty queue.
  - Required: err_underflow=1 stays set, no upd_en, stats unchanged.
  - Then assert reset with 2 entries queued and a resolve accepted in the same cycle. Required: all outputs read their reset values the cycle after the reset edge.
